// File: rtl/tpram_pkg.sv
// Shared definitions for the TPRAM lane controller: access-mode encoding
// and the lane helpers used by the write and read paths.
// The helpers work on one 32-bit slice of the RAM word; the caller selects
// the slice.
package tpram_pkg;

    // Access width encoding shared by the write and read mode ports.
    // The reserved code behaves like a 32-bit access.
    typedef enum logic [1:0] {
        MODE_32  = 2'b00,
        MODE_16  = 2'b01,
        MODE_8   = 2'b10,
        MODE_RSV = 2'b11
    } tpram_mode_e;

    // Round a byte offset inside a 32-bit slice down to the access width.
    function automatic logic [1:0] align_off(input tpram_mode_e mode, input logic [1:0] off);
        logic [1:0] res;
        case (mode)
            MODE_8:  res = off;
            MODE_16: res = {off[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    // An offset is misaligned when it has bits below the access width.
    function automatic logic misaligned(input tpram_mode_e mode, input logic [1:0] off);
        logic res;
        case (mode)
            MODE_8:  res = 1'b0;
            MODE_16: res = off[0];
            default: res = (off != 2'b00);
        endcase
        return res;
    endfunction

    // Byte enables within one 32-bit slice for an already aligned offset.
    function automatic logic [3:0] lane_en(input tpram_mode_e mode, input logic [1:0] off);
        logic [3:0] res;
        case (mode)
            MODE_8:  res = 4'b0001 << off;
            MODE_16: res = off[1] ? 4'b1100 : 4'b0011;
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    // Sub-word write data arrives in the low bits; copy it to every lane
    // so the byte enables alone pick where it lands.
    function automatic logic [31:0] rep_data(input tpram_mode_e mode, input logic [31:0] d);
        logic [31:0] res;
        case (mode)
            MODE_8:  res = {4{d[7:0]}};
            MODE_16: res = {2{d[15:0]}};
            default: res = d;
        endcase
        return res;
    endfunction

    // Move the addressed byte/halfword to bit 0 and zero- or sign-extend it;
    // 32-bit accesses pass the slice through untouched.
    function automatic logic [31:0] extend(input tpram_mode_e mode, input logic sgn,
                                           input logic [31:0] slice, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = slice[7:0];
            2'd1:    b = slice[15:8];
            2'd2:    b = slice[23:16];
            default: b = slice[31:24];
        endcase
        h = off[1] ? slice[31:16] : slice[15:0];
        case (mode)
            MODE_8:  res = {{24{sgn & b[7]}}, b};
            MODE_16: res = {{16{sgn & h[15]}}, h};
            default: res = slice;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tpram_mem_2p.sv
// Two-port RAM, DEPTH x DATA_W, one write port with byte enables and one
// synchronous read port. A same-address read and write in one cycle
// returns the pre-write word. Behavioural model; a hard macro can replace it.
module tpram_mem_2p #(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 512,
    localparam int AW     = $clog2(DEPTH),
    localparam int NB     = DATA_W / 8
) (
    input  logic              mem_clk,
    input  logic              mem_we,
    input  logic [AW-1:0]     mem_waddr,
    input  logic [NB-1:0]     mem_wbe,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_re,
    input  logic [AW-1:0]     mem_raddr,
    output logic [DATA_W-1:0] mem_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-enabled write port.
    always_ff @(posedge mem_clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Synchronous read port; the output register holds until the next read.
    always_ff @(posedge mem_clk) begin
        if (mem_re) begin
            mem_rdata <= mem_q[mem_raddr];
        end
    end

endmodule

// File: rtl/tpram_lane_ctrl.sv
// TPRAM lane controller: byte-addressed 8/16/32-bit access to a wide
// two-port RAM for the fabric and the math block.
// Build option: define TPRAM_WR_BYPASS_EN to have a read that collides with
// a same-cycle write to the same word return the freshly written bytes;
// otherwise the pre-write word is returned.
module tpram_lane_ctrl
    import tpram_pkg::*;
#(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 512,
    localparam int BA_W   = $clog2(DEPTH * DATA_W / 8)
) (
    input  logic            EFPGA_TPRAM_CLK,
    input  logic            EFPGA_TPRAM_RSTN,
    input  logic            EFPGA_TPRAM_POWERDN,
    input  logic [1:0]      EFPGA_TPRAM_W_MODE,
    input  logic [1:0]      EFPGA_TPRAM_R_MODE,
    input  logic            EFPGA_TPRAM_WDSEL,
    input  logic            EFPGA_TPRAM_WE,
    input  logic [BA_W-1:0] EFPGA_TPRAM_W_ADDR,
    input  logic [31:0]     EFPGA_TPRAM_W_DATA,
    input  logic [31:0]     MATHB_TPRAM_W_DATA,
    input  logic            EFPGA_TPRAM_R_REQ,
    output logic            TPRAM_EFPGA_R_REQ_RDY,
    input  logic [BA_W-1:0] EFPGA_TPRAM_R_ADDR,
    input  logic            EFPGA_TPRAM_R_SIGNED,
    output logic            TPRAM_EFPGA_R_VALID,
    input  logic            EFPGA_TPRAM_R_DRDY,
    output logic [31:0]     TPRAM_EFPGA_R_DATA,
    output logic [31:0]     TPRAM_MATHB_R_DATA,
    output logic            TPRAM_EFPGA_COLLISION,
    output logic            TPRAM_EFPGA_ALIGN_ERR
);

    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int AW     = $clog2(DEPTH);
    localparam int NSLICE = DATA_W / 32;
    localparam int SL_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Handshakes:
    //   request : a read is taken on a rising edge where R_REQ and R_REQ_RDY
    //             are both 1. R_REQ_RDY = !POWERDN && (!R_VALID || R_DRDY), so
    //             a new read may be taken in the same cycle the current result
    //             is consumed (no bubble).
    //   response: R_VALID/R_DATA/MATHB_R_DATA stay stable until an edge with
    //             R_DRDY=1 consumes them. Power-down drops R_VALID at the next
    //             edge whether or not the result was consumed.
    //   writes  : taken on any edge with WE=1 and POWERDN=0, never stalled.

    // Write path
    tpram_mode_e       w_mode;
    logic [31:0]       w_data32;
    logic [AW-1:0]     w_word;
    logic [OFF_W-1:0]  w_off;
    logic [SL_W-1:0]   w_slice;
    logic [1:0]        w_lane;
    logic              w_mis;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_data_word;
    logic              we_eff;

    // Read request path
    tpram_mode_e       r_mode;
    logic [AW-1:0]     r_word;
    logic [OFF_W-1:0]  r_off;
    logic [SL_W-1:0]   r_slice;
    logic [1:0]        r_lane;
    logic              r_mis;
    logic              rd_rdy;
    logic              rd_acc;
    logic              coll_now;

    // Registered read context
    logic              r_valid_q;
    logic [SL_W-1:0]   r_slice_q;
    logic [1:0]        r_lane_q;
    tpram_mode_e       r_mode_q;
    logic              r_signed_q;
    logic              coll_q;
    logic              align_err_q;

    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_word;
    logic [31:0]       rd_slice32;

    // Decode the write: the math block always writes full 32-bit words.
    always_comb begin
        w_mode      = EFPGA_TPRAM_WDSEL ? MODE_32 : tpram_mode_e'(EFPGA_TPRAM_W_MODE);
        w_data32    = rep_data(w_mode, EFPGA_TPRAM_WDSEL ? MATHB_TPRAM_W_DATA : EFPGA_TPRAM_W_DATA);
        w_word      = EFPGA_TPRAM_W_ADDR[BA_W-1:OFF_W];
        w_off       = EFPGA_TPRAM_W_ADDR[OFF_W-1:0];
        w_slice     = SL_W'(w_off >> 2);
        w_lane      = align_off(w_mode, w_off[1:0]);
        w_mis       = misaligned(w_mode, w_off[1:0]);
        w_data_word = {NSLICE{w_data32}};
        w_be        = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (SL_W'(s) == w_slice) begin
                w_be[s*4 +: 4] = lane_en(w_mode, w_lane);
            end
        end
    end

    // Decode the read request and the accept/collision conditions.
    always_comb begin
        r_mode   = tpram_mode_e'(EFPGA_TPRAM_R_MODE);
        r_word   = EFPGA_TPRAM_R_ADDR[BA_W-1:OFF_W];
        r_off    = EFPGA_TPRAM_R_ADDR[OFF_W-1:0];
        r_slice  = SL_W'(r_off >> 2);
        r_lane   = align_off(r_mode, r_off[1:0]);
        r_mis    = misaligned(r_mode, r_off[1:0]);
        we_eff   = EFPGA_TPRAM_WE && !EFPGA_TPRAM_POWERDN;
        rd_rdy   = !EFPGA_TPRAM_POWERDN && (!r_valid_q || EFPGA_TPRAM_R_DRDY);
        rd_acc   = EFPGA_TPRAM_R_REQ && rd_rdy;
        coll_now = rd_acc && we_eff && (r_word == w_word);
    end

    // Read-valid tracking, captured read context and the one-cycle status pulses.
    always_ff @(posedge EFPGA_TPRAM_CLK or negedge EFPGA_TPRAM_RSTN) begin
        if (!EFPGA_TPRAM_RSTN) begin
            r_valid_q   <= 1'b0;
            r_slice_q   <= '0;
            r_lane_q    <= 2'b00;
            r_mode_q    <= MODE_32;
            r_signed_q  <= 1'b0;
            coll_q      <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            coll_q      <= coll_now;
            align_err_q <= (we_eff && w_mis) || (rd_acc && r_mis);
            if (EFPGA_TPRAM_POWERDN) begin
                r_valid_q <= 1'b0;
            end else if (rd_acc) begin
                r_valid_q <= 1'b1;
            end else if (EFPGA_TPRAM_R_DRDY) begin
                r_valid_q <= 1'b0;
            end
            if (rd_acc) begin
                r_slice_q  <= r_slice;
                r_lane_q   <= r_lane;
                r_mode_q   <= r_mode;
                r_signed_q <= EFPGA_TPRAM_R_SIGNED;
            end
        end
    end

`ifdef TPRAM_WR_BYPASS_EN
    logic [NB-1:0]     byp_be_q;
    logic [DATA_W-1:0] byp_data_q;

    // Capture the colliding write's bytes alongside the read they must overlay.
    always_ff @(posedge EFPGA_TPRAM_CLK or negedge EFPGA_TPRAM_RSTN) begin
        if (!EFPGA_TPRAM_RSTN) begin
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else if (rd_acc) begin
            byp_be_q   <= coll_now ? w_be : '0;
            byp_data_q <= w_data_word;
        end
    end

    // Merge the written bytes over the pre-write word from the RAM.
    always_comb begin
        rd_word = mem_rdata;
        for (int b = 0; b < NB; b++) begin
            if (byp_be_q[b]) begin
                rd_word[b*8 +: 8] = byp_data_q[b*8 +: 8];
            end
        end
    end
`else
    assign rd_word = mem_rdata;
`endif

    // Pick the addressed 32-bit slice and lane-align it; outputs read as
    // zero whenever no result is valid.
    always_comb begin
        rd_slice32 = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (SL_W'(s) == r_slice_q) begin
                rd_slice32 = rd_word[s*32 +: 32];
            end
        end
        TPRAM_EFPGA_R_DATA = r_valid_q ? extend(r_mode_q, r_signed_q, rd_slice32, r_lane_q) : 32'h0;
        TPRAM_MATHB_R_DATA = r_valid_q ? rd_slice32 : 32'h0;
    end

    assign TPRAM_EFPGA_R_REQ_RDY = rd_rdy;
    assign TPRAM_EFPGA_R_VALID   = r_valid_q;
    assign TPRAM_EFPGA_COLLISION = coll_q;
    assign TPRAM_EFPGA_ALIGN_ERR = align_err_q;

    tpram_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .mem_clk   (EFPGA_TPRAM_CLK),
        .mem_we    (we_eff),
        .mem_waddr (w_word),
        .mem_wbe   (w_be),
        .mem_wdata (w_data_word),
        .mem_re    (rd_acc),
        .mem_raddr (r_word),
        .mem_rdata (mem_rdata)
    );

endmodule

// File: tb/tb_tpram_lane_ctrl.sv
`timescale 1ns/1ps
module tb_tpram_lane_ctrl;

    localparam int DATA_W    = 64;
    localparam int DEPTH     = 512;
    localparam int BA_W      = 12;
    localparam int MEM_BYTES = 4096;

    logic            clk;
    logic            rstn;
    logic            pd;
    logic [1:0]      w_mode;
    logic [1:0]      r_mode;
    logic            wdsel;
    logic            we;
    logic [BA_W-1:0] w_addr;
    logic [31:0]     w_data;
    logic [31:0]     m_data;
    logic            r_req;
    logic            r_rdy;
    logic [BA_W-1:0] r_addr;
    logic            r_sgn;
    logic            r_valid;
    logic            r_drdy;
    logic [31:0]     r_data;
    logic [31:0]     mathb_r_data;
    logic            coll;
    logic            align_err;

    tpram_lane_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .EFPGA_TPRAM_CLK       (clk),
        .EFPGA_TPRAM_RSTN      (rstn),
        .EFPGA_TPRAM_POWERDN   (pd),
        .EFPGA_TPRAM_W_MODE    (w_mode),
        .EFPGA_TPRAM_R_MODE    (r_mode),
        .EFPGA_TPRAM_WDSEL     (wdsel),
        .EFPGA_TPRAM_WE        (we),
        .EFPGA_TPRAM_W_ADDR    (w_addr),
        .EFPGA_TPRAM_W_DATA    (w_data),
        .MATHB_TPRAM_W_DATA    (m_data),
        .EFPGA_TPRAM_R_REQ     (r_req),
        .TPRAM_EFPGA_R_REQ_RDY (r_rdy),
        .EFPGA_TPRAM_R_ADDR    (r_addr),
        .EFPGA_TPRAM_R_SIGNED  (r_sgn),
        .TPRAM_EFPGA_R_VALID   (r_valid),
        .EFPGA_TPRAM_R_DRDY    (r_drdy),
        .TPRAM_EFPGA_R_DATA    (r_data),
        .TPRAM_MATHB_R_DATA    (mathb_r_data),
        .TPRAM_EFPGA_COLLISION (coll),
        .TPRAM_EFPGA_ALIGN_ERR (align_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] exp_m_q[$];
    logic [7:0]  mem_m [MEM_BYTES];
    logic        vld_m;
    logic        coll_pend;
    logic        align_pend;
    logic [31:0] last_rdata;
    logic        saw_coll;
    logic        saw_align;
    logic [31:0] init_word [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Reference model: little-endian byte memory, modes 0/3=32b, 1=16b, 2=8b.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? 2'b00 : m;
    endfunction

    function automatic int m_base(input logic [1:0] m, input int a);
        if (m == 2'b10) return a;
        if (m == 2'b01) return a & ~1;
        return a & ~3;
    endfunction

    function automatic logic m_mis(input logic [1:0] m, input int a);
        if (m == 2'b10) return 1'b0;
        if (m == 2'b01) return (a & 1) != 0;
        return (a & 3) != 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] m, input int a, input logic sgn);
        int b;
        logic [31:0] v;
        b = m_base(m, a);
        if (m == 2'b10)
            v = {{24{sgn & mem_m[b][7]}}, mem_m[b]};
        else if (m == 2'b01)
            v = {{16{sgn & mem_m[b+1][7]}}, mem_m[b+1], mem_m[b]};
        else
            v = {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
        return v;
    endfunction

    function automatic logic [31:0] m_mathb(input int a);
        int s;
        s = a & ~3;
        return {mem_m[s+3], mem_m[s+2], mem_m[s+1], mem_m[s]};
    endfunction

    task automatic m_write(input logic [1:0] m, input int a, input logic [31:0] d);
        int n;
        int b;
        n = (m == 2'b10) ? 1 : ((m == 2'b01) ? 2 : 4);
        b = m_base(m, a);
        for (int k = 0; k < n; k++) mem_m[b+k] = d[8*k +: 8];
    endtask

    // One clock: compare DUT outputs at the falling edge, then advance the model.
    task automatic tick();
        logic        exp_rdy;
        logic        acc;
        logic        we_e;
        logic [1:0]  wm;
        logic [1:0]  rm;
        logic [31:0] wd;
        int          wa;
        int          ra;
        @(negedge clk);
        exp_rdy = !pd && (!vld_m || r_drdy);
        check("r_valid", 32'(r_valid), 32'(vld_m));
        check("r_req_rdy", 32'(r_rdy), 32'(exp_rdy));
        check("collision", 32'(coll), 32'(coll_pend));
        check("align_err", 32'(align_err), 32'(align_pend));
        if (coll) saw_coll = 1'b1;
        if (align_err) saw_align = 1'b1;
        if (vld_m) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("r_data", r_data, exp_q[0]);
                check("mathb_r_data", mathb_r_data, exp_m_q[0]);
                if (r_drdy || pd) begin
                    if (r_drdy) last_rdata = r_data;
                    void'(exp_q.pop_front());
                    void'(exp_m_q.pop_front());
                end
            end
        end
        we_e = we && !pd;
        wm   = wdsel ? 2'b00 : norm_mode(w_mode);
        rm   = norm_mode(r_mode);
        wd   = wdsel ? m_data : w_data;
        wa   = int'(w_addr);
        ra   = int'(r_addr);
        acc  = r_req && exp_rdy;
        coll_pend  = acc && we_e && ((wa >> 3) == (ra >> 3));
        align_pend = (we_e && m_mis(wm, wa)) || (acc && m_mis(rm, ra));
`ifdef TPRAM_WR_BYPASS_EN
        if (we_e) m_write(wm, wa, wd);
        if (acc) begin
            exp_q.push_back(m_read(rm, ra, r_sgn));
            exp_m_q.push_back(m_mathb(ra));
        end
`else
        if (acc) begin
            exp_q.push_back(m_read(rm, ra, r_sgn));
            exp_m_q.push_back(m_mathb(ra));
        end
        if (we_e) m_write(wm, wa, wd);
`endif
        if (pd) vld_m = 1'b0;
        else if (acc) vld_m = 1'b1;
        else if (r_drdy) vld_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reset: outputs must clear asynchronously, before any clock edge.
    task automatic do_reset();
        rstn  = 1'b0;
        r_req = 1'b0;
        we    = 1'b0;
        pd    = 1'b0;
        #1;
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_mathb", mathb_r_data, 32'd0);
        check("rst_collision", 32'(coll), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.delete();
        exp_m_q.delete();
        vld_m      = 1'b0;
        coll_pend  = 1'b0;
        align_pend = 1'b0;
    endtask

    // Driver tasks
    task automatic wr(input logic [1:0] m, input int a, input logic [31:0] d, input logic sel);
        we     = 1'b1;
        w_mode = m;
        w_addr = BA_W'(a);
        wdsel  = sel;
        w_data = sel ? $urandom() : d;
        m_data = sel ? d : $urandom();
        tick();
        we    = 1'b0;
        wdsel = 1'b0;
    endtask

    task automatic rd(input logic [1:0] m, input int a, input logic sgn);
        r_req  = 1'b1;
        r_mode = m;
        r_addr = BA_W'(a);
        r_sgn  = sgn;
        tick();
        r_req = 1'b0;
    endtask

    task automatic drain();
        r_req  = 1'b0;
        we     = 1'b0;
        pd     = 1'b0;
        r_drdy = 1'b1;
        for (int i = 0; i < 6 && (vld_m || exp_q.size() != 0); i++) tick();
    endtask

    // Watchdog
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Stimulus
    initial begin
        logic [31:0] d;
        n_checks  = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        pd        = 1'b0;
        w_mode    = 2'b00;
        r_mode    = 2'b00;
        wdsel     = 1'b0;
        we        = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        m_data    = '0;
        r_req     = 1'b0;
        r_addr    = '0;
        r_sgn     = 1'b0;
        r_drdy    = 1'b1;
        saw_coll  = 1'b0;
        saw_align = 1'b0;
        last_rdata = '0;
        do_reset();
        tick();

        // Preload bytes 0x00..0x3F with random 32-bit words
        for (int i = 0; i < 16; i++) begin
            init_word[i] = $urandom();
            wr(2'b00, i * 4, init_word[i], 1'b0);
        end

        // 8-bit write then signed and unsigned byte reads
        d = $urandom();
        d[7:0] = 8'hA5;
        wr(2'b10, 'h005, d, 1'b0);
        rd(2'b10, 'h005, 1'b1);
        drain();
        check("rd8_signed", last_rdata, 32'hFFFF_FFA5);
        rd(2'b10, 'h005, 1'b0);
        drain();
        check("rd8_unsigned", last_rdata, 32'h0000_00A5);

        // 16-bit write into the upper half of a 32-bit word
        d = $urandom();
        d[15:0] = 16'h1234;
        wr(2'b01, 'h00A, d, 1'b0);
        rd(2'b00, 'h008, 1'b0);
        drain();
        check("rd32_half_merge", last_rdata, {16'h1234, init_word[2][15:0]});

        // Consumer stall with a second request waiting, then back-to-back
        r_drdy = 1'b0;
        rd(2'b00, 'h010, 1'b0);
        r_req  = 1'b1;
        r_addr = BA_W'('h014);
        repeat (3) tick();
        r_drdy = 1'b1;
        tick();
        r_req = 1'b0;
        check("b2b_first", last_rdata, init_word[4]);
        tick();
        check("b2b_second", last_rdata, init_word[5]);
        drain();

        // Same-word write and read in one cycle
        saw_coll = 1'b0;
        we     = 1'b1;
        w_mode = 2'b00;
        w_addr = BA_W'('h010);
        w_data = 32'hDEAD_BEEF;
        r_req  = 1'b1;
        r_mode = 2'b00;
        r_addr = BA_W'('h010);
        tick();
        we    = 1'b0;
        r_req = 1'b0;
        drain();
        check("collision_seen", 32'(saw_coll), 32'd1);
`ifdef TPRAM_WR_BYPASS_EN
        check("collision_data", last_rdata, 32'hDEAD_BEEF);
`else
        check("collision_data", last_rdata, init_word[4]);
`endif
        rd(2'b00, 'h010, 1'b0);
        drain();
        check("collision_written", last_rdata, 32'hDEAD_BEEF);

        // Misaligned 16-bit read is taken from the aligned halfword
        saw_align = 1'b0;
        rd(2'b01, 'h003, 1'b0);
        drain();
        check("align_seen", 32'(saw_align), 32'd1);
        check("align_data", last_rdata, {16'h0000, init_word[0][31:16]});

        // Misaligned 32-bit write lands on the aligned word
        d = $urandom();
        wr(2'b00, 'h021, d, 1'b0);
        rd(2'b00, 'h020, 1'b0);
        drain();
        check("align_wr_data", last_rdata, d);

        // Math-block write is always 32 bits wide, whatever W_MODE says
        d = $urandom();
        wr(2'b10, 'h024, d, 1'b1);
        rd(2'b00, 'h024, 1'b0);
        drain();
        check("wdsel_data", last_rdata, d);
        rd(2'b10, 'h02D, 1'b1);
        drain();

        // Random traffic with occasional power-down and consumer stalls
        for (int i = 0; i < 300; i++) begin
            r_req  = 1'($urandom_range(0, 1));
            r_mode = 2'($urandom_range(0, 3));
            r_addr = BA_W'($urandom_range(0, 63));
            r_sgn  = 1'($urandom_range(0, 1));
            we     = 1'($urandom_range(0, 1));
            w_mode = 2'($urandom_range(0, 3));
            wdsel  = ($urandom_range(0, 3) == 0);
            w_addr = ($urandom_range(0, 3) == 0) ? r_addr : BA_W'($urandom_range(0, 63));
            w_data = $urandom();
            m_data = $urandom();
            r_drdy = 1'($urandom_range(0, 1));
            pd     = ($urandom_range(0, 15) == 0);
            tick();
        end
        wdsel = 1'b0;
        drain();

        // Reset while a read result is outstanding
        r_drdy = 1'b0;
        rd(2'b00, 'h010, 1'b0);
        tick();
        do_reset();
        r_drdy = 1'b1;
        repeat (3) tick();
        check("post_rst_valid", 32'(r_valid), 32'd0);

        // Power-down: requests and writes are ignored
        wr(2'b00, 'h030, 32'h1122_3344, 1'b0);
        pd     = 1'b1;
        we     = 1'b1;
        w_mode = 2'b00;
        w_addr = BA_W'('h030);
        w_data = 32'h5566_7788;
        r_req  = 1'b1;
        r_mode = 2'b00;
        r_addr = BA_W'('h030);
        repeat (2) tick();
        check("pd_rdy", 32'(r_rdy), 32'd0);
        pd    = 1'b0;
        we    = 1'b0;
        r_req = 1'b0;
        tick();
        rd(2'b00, 'h030, 1'b0);
        drain();
        check("pd_write_ignored", last_rdata, 32'h1122_3344);

        // Power-down drops a stalled result
        r_drdy = 1'b0;
        rd(2'b00, 'h030, 1'b0);
        tick();
        pd = 1'b1;
        tick();
        pd = 1'b0;
        tick();
        check("pd_clears_valid", 32'(r_valid), 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
